// File: rtl/cordic_polar_iter.sv
// Iterative CORDIC vectoring: Cartesian (x, y) to magnitude and phase in degrees, one stage per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP cycle that scales the CORDIC gain out of o_mag.
module cordic_polar_iter #(
  parameter int unsigned WIDTH_XY = 32,
  parameter int unsigned WIDTH_PH = 32,
  parameter int unsigned NSTAGES  = 16,
  parameter int unsigned NCH      = 4,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic signed [WIDTH_XY-1:0] i_x,
  input  logic signed [WIDTH_XY-1:0] i_y,
  input  logic [CH_W-1:0]            i_ch,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [WIDTH_XY:0]          o_mag,
  output logic signed [WIDTH_PH-1:0] o_phase,
  output logic [CH_W-1:0]            o_ch
);

  localparam int unsigned XW = WIDTH_XY + 2;
  localparam int unsigned KW = $clog2(NSTAGES);
  localparam int unsigned FB = WIDTH_PH - 10;

  localparam logic signed [WIDTH_PH-1:0] Ph45  = WIDTH_PH'(longint'(45) << FB);
  localparam logic signed [WIDTH_PH-1:0] Ph135 = WIDTH_PH'(longint'(135) << FB);
  localparam logic signed [WIDTH_PH-1:0] Ph180 = WIDTH_PH'(longint'(180) << FB);
  localparam logic signed [WIDTH_PH-1:0] PhN180 = -Ph180;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {StIdle, StBusy, StComp, StOutput} state_e;
`else
  typedef enum logic [1:0] {StIdle, StBusy, StOutput} state_e;
`endif

  // atan(2^-i) in degrees via its Taylor series; the argument never exceeds 0.5.
  function automatic logic signed [WIDTH_PH-1:0] atan_entry(input int i);
    real t, t2, term, sum, deg;
    t = 1.0;
    for (int n = 0; n < i; n++) t = t / 2.0;
    t2   = t * t;
    term = t;
    sum  = 0.0;
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 1) sum = sum - term / real'(2 * n + 1);
      else            sum = sum + term / real'(2 * n + 1);
      term = term * t2;
    end
    deg = sum * 180.0 / 3.14159265358979323846;
    for (int n = 0; n < int'(FB); n++) deg = deg * 2.0;
    return WIDTH_PH'(longint'(deg));
  endfunction

  logic signed [WIDTH_PH-1:0] atan_tab [NSTAGES];
  for (genvar g = 0; g < NSTAGES; g++) begin : g_atan
    assign atan_tab[g] = atan_entry(g + 1);
  end

  state_e                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
  logic signed [WIDTH_PH-1:0] ph_q, ph_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       zero_q, zero_d;

  logic [KW:0]                sh;
  logic signed [XW-1:0]       xe, ye, x_pre, y_pre, y_abs, x_it, y_it;
  logic signed [WIDTH_PH-1:0] ph_pre, ph_it;

  always_comb begin
    xe     = {{2{i_x[WIDTH_XY-1]}}, i_x};
    ye     = {{2{i_y[WIDTH_XY-1]}}, i_y};
    x_pre  = xe - ye;
    y_pre  = xe + ye;
    ph_pre = -Ph45;
    // Fold the vector into the right half-plane near the x axis, gain sqrt(2).
    unique case ({i_y[WIDTH_XY-1], i_x[WIDTH_XY-1]})
      2'b00: begin x_pre = xe + ye;  y_pre = ye - xe;  ph_pre = Ph45;   end
      2'b01: begin x_pre = ye - xe;  y_pre = -xe - ye; ph_pre = Ph135;  end
      2'b11: begin x_pre = -ye - xe; y_pre = xe - ye;  ph_pre = -Ph135; end
      2'b10: begin x_pre = xe - ye;  y_pre = xe + ye;  ph_pre = -Ph45;  end
      default: ;
    endcase
  end

  always_comb begin
    sh    = (KW+1)'(k_q) + (KW+1)'(1);
    y_abs = -y_q;
    if (y_q[XW-1]) begin
      x_it  = x_q + (y_abs >>> sh);
      y_it  = y_q + (x_q >>> sh);
      ph_it = ph_q - atan_tab[k_q];
    end else begin
      x_it  = x_q + (y_q >>> sh);
      y_it  = y_q - (x_q >>> sh);
      ph_it = ph_q + atan_tab[k_q];
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [17:0] GainInv = 18'sd39797;
  logic signed [XW+17:0] prod;
  assign prod = x_q * GainInv;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    ch_d    = ch_q;
    zero_d  = zero_q;
    i_rdy   = 1'b0;
    o_vld   = 1'b0;
    unique case (state_q)
      StIdle: i_rdy = 1'b1;
      StBusy: begin
        x_d  = x_it;
        y_d  = y_it;
        ph_d = ph_it;
        k_d  = k_q + KW'(1);
        if (k_q == KW'(NSTAGES - 1)) begin
          k_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = StComp;
`else
          state_d = StOutput;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      StComp: begin
        x_d     = XW'(prod >>> 16);
        state_d = StOutput;
      end
`endif
      StOutput: begin
        o_vld = 1'b1;
        i_rdy = o_rdy;
        if (o_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new sample overrides the idle/handoff transition, giving back-to-back throughput.
    if (i_vld && i_rdy) begin
      x_d     = x_pre;
      y_d     = y_pre;
      ph_d    = ph_pre;
      ch_d    = i_ch;
      zero_d  = (i_x == '0) && (i_y == '0);
      k_d     = '0;
      state_d = StBusy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= '0;
      ch_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      ch_q    <= ch_d;
      zero_q  <= zero_d;
    end
  end

  assign o_mag   = zero_q ? '0 : x_q[WIDTH_XY:0];
  assign o_phase = zero_q ? '0 : ((ph_q == PhN180) ? Ph180 : ph_q);
  assign o_ch    = ch_q;

endmodule

// File: tb/tb_cordic_polar_iter.sv
// Self-checking bench for cordic_polar_iter against a floating-point atan2/hypot reference.
module tb_cordic_polar_iter;

  localparam int WXY = 16;
  localparam int WPH = 32;
  localparam int NST = 16;
  localparam int NCH = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = NST + 2;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = NST + 1;
  localparam bit COMP = 1'b0;
`endif
  localparam real PI = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_vld;
  logic                  i_rdy;
  logic signed [WXY-1:0] i_x;
  logic signed [WXY-1:0] i_y;
  logic [1:0]            i_ch;
  logic                  o_vld;
  logic                  o_rdy;
  logic [WXY:0]          o_mag;
  logic signed [WPH-1:0] o_phase;
  logic [1:0]            o_ch;

  int  checks = 0;
  int  failures = 0;
  real kc;

  cordic_polar_iter #(
    .WIDTH_XY(WXY),
    .WIDTH_PH(WPH),
    .NSTAGES (NST),
    .NCH     (NCH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (i_vld),
    .i_rdy  (i_rdy),
    .i_x    (i_x),
    .i_y    (i_y),
    .i_ch   (i_ch),
    .o_vld  (o_vld),
    .o_rdy  (o_rdy),
    .o_mag  (o_mag),
    .o_phase(o_phase),
    .o_ch   (o_ch)
  );

  always #5 clk = ~clk;

  // Reference model: ideal polar conversion scaled by the CORDIC gain.
  function automatic real radius(int x, int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  function automatic real ref_mag(int x, int y);
    return COMP ? radius(x, y) * kc * 39797.0 / 65536.0 : radius(x, y) * kc;
  endfunction

  function automatic real ref_phase(int x, int y);
    real p;
    if (x == 0 && y == 0) return 0.0;
    p = $atan2(real'(y), real'(x)) * 180.0 / PI;
    return (p <= -180.0) ? 180.0 : p;
  endfunction

  // Integer datapath limits accuracy to a few LSBs of the rotated vector.
  function automatic real mag_tol(int x, int y);
    return (x == 0 && y == 0) ? 0.0 : 0.002 * ref_mag(x, y) + 20.0;
  endfunction

  function automatic real ph_tol(int x, int y);
    return (x == 0 && y == 0) ? 0.0 : 0.002 + 16.0 / (kc * radius(x, y)) * 180.0 / PI;
  endfunction

  function automatic real deg_of(logic signed [WPH-1:0] p);
    return $itor(p) / 4194304.0;
  endfunction

  function automatic real ang_err(real got, real want);
    real d = got - want;
    while (d > 180.0) d = d - 360.0;
    while (d <= -180.0) d = d + 360.0;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real mag_err(real got, real want);
    return (got > want) ? got - want : want - got;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int x, input int y, input int ch, output bit ok);
    int n = 0;
    while (!i_rdy && n < 50) begin
      tick();
      n++;
    end
    ok    = i_rdy;
    i_x   = 16'(x);
    i_y   = 16'(y);
    i_ch  = 2'(ch);
    i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accept edge; -1 means o_vld never came.
  task automatic wait_vld(output int lat);
    int n = 1;
    while (!o_vld && n < 100) begin
      tick();
      n++;
    end
    lat = o_vld ? n : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_vld = 1'b0; o_rdy = 1'b1; i_x = '0; i_y = '0; i_ch = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL reset_o_vld got %b want 0", o_vld); end
    checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL reset_i_rdy got %b want 1", i_rdy); end
    checks++; if (o_mag !== '0) begin failures++; $display("FAIL reset_o_mag got %0d want 0", o_mag); end
    checks++; if (o_phase !== '0) begin failures++; $display("FAIL reset_o_phase got %h want 0", o_phase); end
    checks++; if (o_ch !== '0) begin failures++; $display("FAIL reset_o_ch got %0d want 0", o_ch); end
  endtask

  task automatic test_axes();
    int ax [5] = '{1000, 0, -1000, 0, 0};
    int ay [5] = '{0, 1000, 0, -1000, 0};
    int ac [5] = '{2, 1, 3, 0, 2};
    int lat;
    bit ok;
    o_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ax[i], ay[i], ac[i], ok);
      wait_vld(lat);
      checks++;
      if (!ok || lat !== LAT) begin
        failures++; $display("FAIL axis%0d_latency got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (o_ch !== 2'(ac[i])) begin
        failures++; $display("FAIL axis%0d_ch got %0d want %0d", i, o_ch, ac[i]);
      end
      checks++;
      if (mag_err(real'(o_mag), ref_mag(ax[i], ay[i])) > mag_tol(ax[i], ay[i])) begin
        failures++;
        $display("FAIL axis%0d_mag got %0d want %f", i, o_mag, ref_mag(ax[i], ay[i]));
      end
      checks++;
      if (ang_err(deg_of(o_phase), ref_phase(ax[i], ay[i])) > ph_tol(ax[i], ay[i])) begin
        failures++;
        $display("FAIL axis%0d_phase got %f want %f", i, deg_of(o_phase), ref_phase(ax[i], ay[i]));
      end
      if (ax[i] < 0) begin
        checks++;
        if (o_phase[WPH-1] !== 1'b0) begin
          failures++; $display("FAIL axis%0d_phase_sign got %h want non-negative", i, o_phase);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int x, y, ch, lat;
    bit ok;
    o_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x  = int'($urandom_range(40000)) - 20000;
      y  = int'($urandom_range(40000)) - 20000;
      ch = int'($urandom_range(3));
      if (x < 2000 && x > -2000 && y < 2000 && y > -2000) x = 12345;
      issue(x, y, ch, ok);
      wait_vld(lat);
      checks++;
      if (!ok || lat !== LAT) begin
        failures++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (o_ch !== 2'(ch)) begin
        failures++; $display("FAIL rand%0d_ch got %0d want %0d", i, o_ch, ch);
      end
      checks++;
      if (mag_err(real'(o_mag), ref_mag(x, y)) > mag_tol(x, y)) begin
        failures++;
        $display("FAIL rand%0d_mag (%0d,%0d) got %0d want %f", i, x, y, o_mag, ref_mag(x, y));
      end
      checks++;
      if (ang_err(deg_of(o_phase), ref_phase(x, y)) > ph_tol(x, y)) begin
        failures++;
        $display("FAIL rand%0d_phase (%0d,%0d) got %f want %f", i, x, y, deg_of(o_phase),
                 ref_phase(x, y));
      end
      tick();
    end
  endtask

  // Leaves the DUT stalled in OUTPUT with the next sample presented on i_x/i_y.
  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [WXY:0]          m0;
    logic signed [WPH-1:0] p0;
    logic [1:0]            c0;
    o_rdy = 1'b0;
    issue(3000, -4000, 1, ok);
    wait_vld(lat);
    checks++;
    if (!ok || lat !== LAT) begin
      failures++; $display("FAIL bp_latency got %0d want %0d", lat, LAT);
    end
    checks++;
    if (mag_err(real'(o_mag), ref_mag(3000, -4000)) > mag_tol(3000, -4000) ||
        ang_err(deg_of(o_phase), ref_phase(3000, -4000)) > ph_tol(3000, -4000) ||
        o_ch !== 2'd1) begin
      failures++;
      $display("FAIL bp_result got mag %0d phase %f ch %0d want mag %f phase %f ch 1", o_mag,
               deg_of(o_phase), o_ch, ref_mag(3000, -4000), ref_phase(3000, -4000));
    end
    m0 = o_mag; p0 = o_phase; c0 = o_ch;
    i_x = 16'sd1234; i_y = 16'sd5678; i_ch = 2'd3; i_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL bp%0d_o_vld got %b want 1", c, o_vld); end
      checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL bp%0d_i_rdy got %b want 0", c, i_rdy); end
      checks++;
      if (o_mag !== m0 || o_phase !== p0 || o_ch !== c0) begin
        failures++;
        $display("FAIL bp%0d_stable got %0d/%h/%0d want %0d/%h/%0d", c, o_mag, o_phase, o_ch,
                 m0, p0, c0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    o_rdy = 1'b1;
    #1;
    checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL b2b_i_rdy got %b want 1", i_rdy); end
    tick();
    i_vld = 1'b0;
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL b2b_o_vld_drop got %b want 0", o_vld); end
    wait_vld(lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (o_ch !== 2'd3) begin failures++; $display("FAIL b2b_ch got %0d want 3", o_ch); end
    checks++;
    if (mag_err(real'(o_mag), ref_mag(1234, 5678)) > mag_tol(1234, 5678)) begin
      failures++; $display("FAIL b2b_mag got %0d want %f", o_mag, ref_mag(1234, 5678));
    end
    checks++;
    if (ang_err(deg_of(o_phase), ref_phase(1234, 5678)) > ph_tol(1234, 5678)) begin
      failures++; $display("FAIL b2b_phase got %f want %f", deg_of(o_phase), ref_phase(1234, 5678));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    o_rdy = 1'b1;
    issue(5000, 3000, 3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_accept got i_rdy 0 want 1"); end
    repeat (7) tick();
    rst = 1'b1;
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL rmid_o_vld got %b want 0", o_vld); end
    checks++;
    if (o_mag !== '0 || o_phase !== '0 || o_ch !== '0) begin
      failures++; $display("FAIL rmid_outputs got %0d/%h/%0d want 0/0/0", o_mag, o_phase, o_ch);
    end
    rst = 1'b0;
    tick();
    checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL rmid_i_rdy got %b want 1", i_rdy); end
    repeat (40) begin
      if (o_vld) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_stale got %0d o_vld cycles want 0", seen); end
  endtask

  initial begin
    real t;
    kc = $sqrt(2.0);
    t  = 1.0;
    for (int i = 1; i <= NST; i++) begin
      t  = t / 4.0;
      kc = kc * $sqrt(1.0 + t);
    end
    test_reset();
    test_axes();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
